// File: rtl/button_gesture_pkg.sv
// rtl/button_gesture_pkg.sv - shared state encoding and counter sizing for button_gesture
package button_gesture_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    HELD   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } gesture_state_t;

  // One counter serves every timed state, so it must reach the largest threshold.
  function automatic int gesture_cnt_width(input int long_c, input int gap_c, input int rep_c);
    int m;
    m = long_c;
    if (gap_c > m) m = gap_c;
    if (rep_c > m) m = rep_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_gesture_timer.sv
// rtl/button_gesture_timer.sv - gesture_timer: sync-clear saturating up-counter
module gesture_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (count_q != {W{1'b1}}) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/button_gesture.sv
// rtl/button_gesture.sv - short/long/double press classifier; BUTTON_GESTURE_REPEAT_EN adds long_press auto-repeat
module button_gesture
  import button_gesture_pkg::*;
#(
  parameter logic PRESSED_LEVEL     = 1'b0,
  parameter int   LONG_CYCLES       = 5000000,
  parameter int   DOUBLE_GAP_CYCLES = 2500000,
  parameter int   REPEAT_CYCLES     = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic pressed,
  output logic short_press,
  output logic long_press,
  output logic double_press,
  output logic busy
);

  localparam int CNT_W = gesture_cnt_width(LONG_CYCLES, DOUBLE_GAP_CYCLES, REPEAT_CYCLES);

  gesture_state_t state_q, state_d;
  logic             armed_q;
  logic             pressed_q, short_q, long_q, double_q;
  logic             short_d, long_d, double_d;
  logic             repeat_hit;
  logic             is_pressed;
  logic             clr;
  logic [CNT_W-1:0] count;

  assign is_pressed = (in == PRESSED_LEVEL);

  // Releases and presses win over timer thresholds hit in the same cycle.
  always_comb begin
    state_d    = state_q;
    short_d    = 1'b0;
    long_d     = 1'b0;
    double_d   = 1'b0;
    repeat_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed_q && is_pressed) state_d = PRESS1;
      end
      PRESS1: begin
        if (!is_pressed) begin
          state_d = GAP;
        end else if (count == CNT_W'(LONG_CYCLES - 1)) begin
          long_d  = 1'b1;
          state_d = HELD;
        end
      end
      HELD: begin
        if (!is_pressed) begin
          state_d = IDLE;
        end
`ifdef BUTTON_GESTURE_REPEAT_EN
        else if (count == CNT_W'(REPEAT_CYCLES - 1)) begin
          long_d     = 1'b1;
          repeat_hit = 1'b1;
        end
`endif
      end
      GAP: begin
        if (is_pressed) begin
          state_d = PRESS2;
        end else if (count == CNT_W'(DOUBLE_GAP_CYCLES - 1)) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      PRESS2: begin
        if (!is_pressed) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign clr = (state_d != state_q) || repeat_hit;

  gesture_timer #(.W(CNT_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (clr),
    .count_o (count)
  );

  // A button held across reset stays ignored until it is seen released once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      pressed_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      double_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_q | ~is_pressed;
      pressed_q <= is_pressed;
      short_q   <= short_d;
      long_q    <= long_d;
      double_q  <= double_d;
    end
  end

  assign pressed      = pressed_q;
  assign short_press  = short_q;
  assign long_press   = long_q;
  assign double_press = double_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_button_gesture.sv
// tb/tb_button_gesture.sv - directed self-checking bench for button_gesture (LONG=10, GAP=6, REPEAT=4)
module tb_button_gesture;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in  = 1'b1;
  logic pressed, short_press, long_press, double_press, busy;

  int checks = 0;
  int errors = 0;

`ifdef BUTTON_GESTURE_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  button_gesture #(
    .PRESSED_LEVEL     (1'b0),
    .LONG_CYCLES       (10),
    .DOUBLE_GAP_CYCLES (6),
    .REPEAT_CYCLES     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in),
    .pressed      (pressed),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [2:0] exp;
    rst = 1'b1;
    in  = 1'b0;
    tick;
    tick;
    checks++;
    if ({pressed, short_press, long_press, double_press, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=%b",
               {pressed, short_press, long_press, double_press, busy}, 5'b0);
    end
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick;
      checks++;
      if ({short_press, long_press, double_press, busy} !== 4'b0) begin
        errors++;
        $display("FAIL held_through_reset n=%0d got=%b exp=%b", n,
                 {short_press, long_press, double_press, busy}, 4'b0);
      end
    end
    checks++;
    if (pressed !== 1'b1) begin
      errors++;
      $display("FAIL pressed_level got=%b exp=1", pressed);
    end
    for (int n = 0; n < 13; n++) begin
      in = (n >= 1 && n < 4) ? 1'b0 : 1'b1;
      tick;
      exp = {(n == 10), 1'b0, 1'b0};
      checks++;
      if ({short_press, long_press, double_press} !== exp) begin
        errors++;
        $display("FAIL rearm_short n=%0d got=%b exp=%b", n,
                 {short_press, long_press, double_press}, exp);
      end
    end
  endtask

  task automatic test_short;
    logic [2:0] exp;
    for (int n = 0; n < 15; n++) begin
      in = (n < 3) ? 1'b0 : 1'b1;
      tick;
      exp = {(n == 9), 1'b0, 1'b0};
      checks++;
      if ({short_press, long_press, double_press} !== exp) begin
        errors++;
        $display("FAIL short_pulses n=%0d got=%b exp=%b", n,
                 {short_press, long_press, double_press}, exp);
      end
      checks++;
      if (pressed !== (n < 3)) begin
        errors++;
        $display("FAIL short_pressed n=%0d got=%b exp=%b", n, pressed, (n < 3));
      end
      checks++;
      if (busy !== (n < 9)) begin
        errors++;
        $display("FAIL short_busy n=%0d got=%b exp=%b", n, busy, (n < 9));
      end
    end
  endtask

  task automatic test_long;
    logic [2:0] exp;
    logic       l;
    for (int n = 0; n < 30; n++) begin
      in = (n < 23) ? 1'b0 : 1'b1;
      tick;
      l = (n == 10) || (REP && n > 10 && n <= 22 && ((n - 10) % 4 == 0));
      exp = {1'b0, l, 1'b0};
      checks++;
      if ({short_press, long_press, double_press} !== exp) begin
        errors++;
        $display("FAIL long_pulses n=%0d got=%b exp=%b", n,
                 {short_press, long_press, double_press}, exp);
      end
      checks++;
      if (busy !== (n < 23)) begin
        errors++;
        $display("FAIL long_busy n=%0d got=%b exp=%b", n, busy, (n < 23));
      end
    end
  endtask

  task automatic test_double;
    logic [2:0] exp;
    for (int n = 0; n < 20; n++) begin
      in = (n < 3 || (n >= 6 && n < 9)) ? 1'b0 : 1'b1;
      tick;
      exp = {1'b0, 1'b0, (n == 9)};
      checks++;
      if ({short_press, long_press, double_press} !== exp) begin
        errors++;
        $display("FAIL double_pulses n=%0d got=%b exp=%b", n,
                 {short_press, long_press, double_press}, exp);
      end
      checks++;
      if (busy !== (n < 9)) begin
        errors++;
        $display("FAIL double_busy n=%0d got=%b exp=%b", n, busy, (n < 9));
      end
    end
  endtask

  task automatic test_priority;
    logic [2:0] exp;
    for (int n = 0; n < 30; n++) begin
      in = (n < 10 || (n >= 16 && n < 19)) ? 1'b0 : 1'b1;
      tick;
      exp = {1'b0, 1'b0, (n == 19)};
      checks++;
      if ({short_press, long_press, double_press} !== exp) begin
        errors++;
        $display("FAIL priority_pulses n=%0d got=%b exp=%b", n,
                 {short_press, long_press, double_press}, exp);
      end
      checks++;
      if (busy !== (n < 19)) begin
        errors++;
        $display("FAIL priority_busy n=%0d got=%b exp=%b", n, busy, (n < 19));
      end
    end
  endtask

  task automatic test_async_reset_in_gap;
    for (int n = 0; n < 5; n++) begin
      in = (n < 3) ? 1'b0 : 1'b1;
      tick;
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL gap_busy_before_reset got=%b exp=1", busy);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({pressed, short_press, long_press, double_press, busy} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset_outputs got=%b exp=%b",
               {pressed, short_press, long_press, double_press, busy}, 5'b0);
    end
    tick;
    rst = 1'b0;
    for (int n = 0; n < 12; n++) begin
      tick;
      checks++;
      if ({short_press, long_press, double_press, busy} !== 4'b0) begin
        errors++;
        $display("FAIL after_gap_reset n=%0d got=%b exp=%b", n,
                 {short_press, long_press, double_press, busy}, 4'b0);
      end
    end
  endtask

  initial begin
    test_reset;
    test_short;
    test_long;
    test_double;
    test_priority;
    test_async_reset_in_gap;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
